seq_ctrl: RTL and testbench



---
 rtl/seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_seq_ctrl.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl.sv
// ---------------------------------------------------------------------------
// seq_ctrl -- multi-cycle instruction sequencer for the SISC core.
//
// Owns the program counter and instruction register. It fetches one
// instruction word at a time from instruction memory over a req/ack
// handshake, then walks the instruction through DECODE, EXECUTE, MEM and
// WRITEBACK. It drives the register-file write enable, the ALU operation
// class and the status-register update strobe. Conditional branches are
// resolved in EXECUTE against the 4-bit status flags.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   imem_req    fetch request, high for the whole FETCH state
//   imem_addr   fetch address (always equal to pc)
//   imem_ack    fetch data valid; only honoured in FETCH
//   imem_rdata  fetched instruction word
//   stat        status flags, sampled only in EXECUTE
//   ir          latched instruction word
//   pc          program counter (already incremented past the fetched word)
//   rf_we       register-file write enable (ALU class, WRITEBACK)
//   wb_sel      write-back mux select, tied to the ALU result (0)
//   alu_op      4'b0001 from EXECUTE through WRITEBACK for ALU class
//   stat_we     status-register update strobe (ALU class, EXECUTE)
//   halted      core stopped on HLT; only rst leaves this state
//   icount      retired-instruction counter (HLT is not counted)
// ---------------------------------------------------------------------------
module seq_ctrl #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic [3:0]      stat,
  output logic [31:0]     ir,
  output logic [PC_W-1:0] pc,
  output logic            rf_we,
  output logic            wb_sel,
  output logic [3:0]      alu_op,
  output logic            stat_we,
  output logic            halted,
  output logic [15:0]     icount
);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_ALU = 4'h1;
  localparam logic [3:0] OP_BRA = 4'h2;
  localparam logic [3:0] OP_BRR = 4'h3;
  localparam logic [3:0] OP_BNE = 4'h4;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] ALU_CLASS = 4'b0001;

  state_t state;
  state_t state_next;

  logic [3:0]      opcode;
  logic [3:0]      cond_mask;
  logic            flag_hit;
  logic            take_branch;
  logic            is_alu;
  logic [PC_W-1:0] branch_target;

  // Instruction field taps; ir is stable from the fetch-ack edge until the
  // next fetch-ack, so everything decoded from it is glitch-free per state.
  assign opcode    = ir[31:28];
  assign cond_mask = ir[27:24];
  assign is_alu    = (opcode == OP_ALU);
  assign flag_hit  = |(cond_mask & stat);

  // Branch decision. Only consumed by the EXECUTE arm of the datapath
  // register, which is what confines stat sampling to that single cycle.
  always_comb begin
    take_branch = 1'b0;
    case (opcode)
      OP_BRA, OP_BRR: take_branch = flag_hit;
      OP_BNE:         take_branch = ~flag_hit;
      default:        take_branch = 1'b0;
    endcase
  end

  // BRR is relative to the already-incremented pc; the sum wraps naturally
  // at the pc width. BRA and BNE use the low bits of ir as an absolute target.
  assign branch_target = (opcode == OP_BRR) ? (pc + ir[PC_W-1:0]) : ir[PC_W-1:0];

  // The fetch address is the program counter itself, so it cannot move while
  // a request is outstanding: pc only changes on the accepting edge.
  assign imem_addr = pc;

  assign wb_sel = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. Outputs depend only on the state register
  // and ir, never on imem_ack or stat, so there is no input-to-output path.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    rf_we      = 1'b0;
    stat_we    = 1'b0;
    alu_op     = 4'b0000;
    halted     = 1'b0;
    case (state)
      S_RESET: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        stat_we    = is_alu;
        alu_op     = is_alu ? ALU_CLASS : 4'b0000;
        state_next = S_MEM;
      end
      S_MEM: begin
        alu_op     = is_alu ? ALU_CLASS : 4'b0000;
        state_next = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        rf_we      = is_alu;
        alu_op     = is_alu ? ALU_CLASS : 4'b0000;
        state_next = S_FETCH;
      end
      S_HALT: begin
        halted     = 1'b1;
        state_next = S_HALT;
      end
      default: begin
        state_next = S_RESET;
      end
    endcase
  end

  // Architectural registers: pc, ir and the retired-instruction counter.
  // HLT never reaches WRITEBACK, which is why it is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      ir     <= '0;
      icount <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir <= imem_rdata;
            pc <= pc + PC_W'(1);
          end
        end
        S_EXECUTE: begin
          if (take_branch) begin
            pc <= branch_target;
          end
        end
        S_WRITEBACK: begin
          icount <= icount + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_ctrl -- self-checking bench for seq_ctrl.
//
// A behavioural model keeps the architectural program counter and retired
// count and computes each next fetch address from the branch rules with
// plain arithmetic. Per-instruction strobe timing is compared as bit-vectors
// indexed by the number of cycles after the fetch-ack edge.
// ---------------------------------------------------------------------------
module tb_seq_ctrl;

  localparam int PC_W = 16;

  // Expected strobe patterns, bit k = k cycles after the fetch-ack edge.
  localparam logic [15:0] EXP_STAT_WE = 16'h0004;
  localparam logic [15:0] EXP_RF_WE   = 16'h0010;
  localparam logic [15:0] EXP_ALU     = 16'h001C;
  localparam logic [15:0] EXP_REQ     = 16'h0020;
  localparam logic [15:0] EXP_HALTED  = 16'h1FFC;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [3:0]      stat;
  logic [31:0]     ir;
  logic [PC_W-1:0] pc;
  logic            rf_we;
  logic            wb_sel;
  logic [3:0]      alu_op;
  logic            stat_we;
  logic            halted;
  logic [15:0]     icount;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state.
  logic [15:0] m_pc;
  logic [15:0] m_icount;

  // Observations captured by run_instr.
  logic        obs_timeout;
  logic        obs_wait_ok;
  logic        obs_misc_bad;
  logic [15:0] obs_start_addr;
  logic [15:0] obs_fetch_pc;
  logic [31:0] obs_ir;
  logic [15:0] obs_next_addr;
  logic [15:0] obs_icount;
  logic [15:0] obs_stat_we_v;
  logic [15:0] obs_rf_we_v;
  logic [15:0] obs_alu_v;
  logic [15:0] obs_req_v;
  logic [15:0] obs_halted_v;

  seq_ctrl #(.PC_W(PC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stat       (stat),
    .ir         (ir),
    .pc         (pc),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .alu_op     (alu_op),
    .stat_we    (stat_we),
    .halted     (halted),
    .icount     (icount)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Next fetch address after executing word w fetched from address at.
  function automatic logic [15:0] ref_next_pc(input logic [15:0] at, input logic [31:0] w,
                                              input logic [3:0] st);
    logic [15:0] seq;
    logic        hit;
    seq = at + 16'd1;
    hit = (w[27:24] & st) != 4'd0;
    case (w[31:28])
      4'h2:    return hit ? w[15:0] : seq;
      4'h3:    return hit ? 16'(seq + w[15:0]) : seq;
      4'h4:    return hit ? seq : w[15:0];
      default: return seq;
    endcase
  endfunction

  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    imem_ack = 1'b0;
    repeat (cycles) @(negedge clk);
    rst      = 1'b0;
    m_pc     = 16'd0;
    m_icount = 16'd0;
  endtask

  // Waits (bounded) for a fetch request, holds ack low for 'waits' cycles,
  // delivers 'word', then observes 'post' cycles. stat carries 'st' only in
  // the third cycle after the ack edge and random noise elsewhere; ack is
  // randomly toggled with junk data while no fetch is pending.
  task automatic run_instr(input logic [31:0] word, input int waits, input logic [3:0] st,
                           input int post);
    int n;
    obs_timeout   = 1'b0;
    obs_wait_ok   = 1'b1;
    obs_misc_bad  = 1'b0;
    obs_stat_we_v = '0;
    obs_rf_we_v   = '0;
    obs_alu_v     = '0;
    obs_req_v     = '0;
    obs_halted_v  = '0;
    imem_ack      = 1'b0;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      obs_timeout = 1'b1;
      return;
    end
    obs_start_addr = imem_addr;
    obs_fetch_pc   = pc;
    for (int w = 0; w < waits; w++) begin
      imem_rdata = $urandom;
      stat       = 4'($urandom);
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== obs_start_addr) obs_wait_ok = 1'b0;
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    stat       = 4'($urandom);
    for (int k = 1; k <= post; k++) begin
      @(negedge clk);
      obs_stat_we_v[k] = stat_we;
      obs_rf_we_v[k]   = rf_we;
      obs_alu_v[k]     = (alu_op == 4'b0001);
      obs_req_v[k]     = imem_req;
      obs_halted_v[k]  = halted;
      if ((alu_op != 4'b0000 && alu_op != 4'b0001) || wb_sel !== 1'b0) obs_misc_bad = 1'b1;
      if (k == 1) obs_ir = ir;
      if (k == post) begin
        obs_next_addr = imem_addr;
        obs_icount    = icount;
      end
      stat = (k == 2) ? st : 4'($urandom);
      if (k == post) begin
        imem_ack = 1'b0;
      end else begin
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
      end
    end
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if ({imem_req, rf_we, stat_we, alu_op, wb_sel, halted, pc, ir, icount, imem_addr} !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset outputs cycle %0d: req=%b rf_we=%b stat_we=%b alu_op=%h halted=%b pc=%h ir=%h icount=%h expected all zero",
                 c, imem_req, rf_we, stat_we, alu_op, halted, pc, ir, icount);
      end
    end
    rst = 1'b0;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset release req: got %b expected 0", imem_req);
    end
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL first fetch: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
    end
    tests_run++;
    if (ir !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL ack ignored in RESET: got ir=%h expected 00000000", ir);
    end
    imem_ack = 1'b0;
    m_pc     = 16'd0;
    m_icount = 16'd0;
  endtask

  task automatic test_alu_timing(input int waits);
    logic [31:0] word;
    logic [3:0]  st;
    logic [15:0] exp_next;
    word = {4'h1, 28'($urandom)};
    st   = 4'($urandom);
    exp_next = ref_next_pc(m_pc, word, st);
    run_instr(word, waits, st, 5);
    m_icount = m_icount + 16'd1;
    tests_run++;
    if (obs_timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL alu(wait=%0d) fetch timeout: got no req expected req", waits);
    end
    tests_run++;
    if (obs_start_addr !== m_pc || obs_fetch_pc !== m_pc || obs_wait_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL alu(wait=%0d) fetch addr: got addr=%h pc=%h stable=%b expected %h stable=1",
               waits, obs_start_addr, obs_fetch_pc, obs_wait_ok, m_pc);
    end
    tests_run++;
    if (obs_ir !== word) begin
      tests_failed++;
      $display("[TB] FAIL alu(wait=%0d) ir: got %h expected %h", waits, obs_ir, word);
    end
    tests_run++;
    if (obs_stat_we_v !== EXP_STAT_WE) begin
      tests_failed++;
      $display("[TB] FAIL alu(wait=%0d) stat_we timing: got %h expected %h", waits, obs_stat_we_v, EXP_STAT_WE);
    end
    tests_run++;
    if (obs_rf_we_v !== EXP_RF_WE) begin
      tests_failed++;
      $display("[TB] FAIL alu(wait=%0d) rf_we timing: got %h expected %h", waits, obs_rf_we_v, EXP_RF_WE);
    end
    tests_run++;
    if (obs_alu_v !== EXP_ALU || obs_misc_bad !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL alu(wait=%0d) alu_op window: got %h bad=%b expected %h bad=0", waits, obs_alu_v, obs_misc_bad, EXP_ALU);
    end
    tests_run++;
    if (obs_req_v !== EXP_REQ || obs_next_addr !== exp_next) begin
      tests_failed++;
      $display("[TB] FAIL alu(wait=%0d) next fetch: got req=%h addr=%h expected req=%h addr=%h",
               waits, obs_req_v, obs_next_addr, EXP_REQ, exp_next);
    end
    tests_run++;
    if (obs_icount !== m_icount) begin
      tests_failed++;
      $display("[TB] FAIL alu(wait=%0d) icount: got %0d expected %0d", waits, obs_icount, m_icount);
    end
    m_pc = exp_next;
  endtask

  task automatic test_branches;
    logic [31:0] words [8];
    logic [15:0] exp_addr [8];
    words[0] = {4'h2, 4'b0100, 8'h5A, 16'h0020}; exp_addr[0] = 16'h0020;
    words[1] = {4'h2, 4'b0010, 8'hC3, 16'h0040}; exp_addr[1] = 16'h0021;
    words[2] = {4'h2, 4'b0100, 8'h00, 16'h0005}; exp_addr[2] = 16'h0005;
    words[3] = {4'h3, 4'b0100, 8'h11, 16'hFFFE}; exp_addr[3] = 16'h0004;
    words[4] = {4'h4, 4'b0010, 8'h22, 16'h0100}; exp_addr[4] = 16'h0100;
    words[5] = {4'h4, 4'b0100, 8'h33, 16'h0200}; exp_addr[5] = 16'h0101;
    words[6] = {4'h3, 4'b0100, 8'h44, 16'h0010}; exp_addr[6] = 16'h0112;
    words[7] = {4'h3, 4'b1011, 8'h55, 16'h0010}; exp_addr[7] = 16'h0113;
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      run_instr(words[i], i % 2, 4'b0100, 5);
      m_icount = m_icount + 16'd1;
      tests_run++;
      if (obs_timeout !== 1'b0 || obs_start_addr !== m_pc) begin
        tests_failed++;
        $display("[TB] FAIL branch %0d fetch: got timeout=%b addr=%h expected timeout=0 addr=%h",
                 i, obs_timeout, obs_start_addr, m_pc);
      end
      tests_run++;
      if (obs_next_addr !== exp_addr[i] || obs_req_v !== EXP_REQ) begin
        tests_failed++;
        $display("[TB] FAIL branch %0d target: got addr=%h req=%h expected addr=%h req=%h",
                 i, obs_next_addr, obs_req_v, exp_addr[i], EXP_REQ);
      end
      tests_run++;
      if ({obs_stat_we_v, obs_rf_we_v, obs_alu_v} !== '0 || obs_icount !== m_icount) begin
        tests_failed++;
        $display("[TB] FAIL branch %0d side effects: got stat_we=%h rf_we=%h alu=%h icount=%0d expected 0 0 0 %0d",
                 i, obs_stat_we_v, obs_rf_we_v, obs_alu_v, obs_icount, m_icount);
      end
      m_pc = exp_addr[i];
    end
  endtask

  task automatic test_pc_wrap;
    run_instr({4'h2, 4'b1111, 8'h00, 16'hFFFF}, 0, 4'b0001, 5);
    m_icount = m_icount + 16'd1;
    tests_run++;
    if (obs_next_addr !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL wrap setup: got addr=%h expected ffff", obs_next_addr);
    end
    run_instr({4'h0, 28'($urandom)}, 0, 4'($urandom), 5);
    m_icount = m_icount + 16'd1;
    tests_run++;
    if (obs_start_addr !== 16'hFFFF || obs_next_addr !== 16'h0000 || obs_icount !== m_icount) begin
      tests_failed++;
      $display("[TB] FAIL pc wrap: got from=%h next=%h icount=%0d expected ffff 0000 %0d",
               obs_start_addr, obs_next_addr, obs_icount, m_icount);
    end
    m_pc = 16'h0000;
  endtask

  task automatic test_random;
    logic [31:0] word;
    logic [3:0]  st;
    logic [15:0] exp_next;
    logic        alu;
    int          waits;
    do_reset(2);
    for (int i = 0; i < 120; i++) begin
      word  = {4'($urandom_range(0, 14)), 28'($urandom)};
      st    = 4'($urandom);
      waits = $urandom_range(0, 3);
      alu   = (word[31:28] == 4'h1);
      exp_next = ref_next_pc(m_pc, word, st);
      run_instr(word, waits, st, 5);
      m_icount = m_icount + 16'd1;
      tests_run++;
      if (obs_timeout !== 1'b0 || obs_start_addr !== m_pc || obs_wait_ok !== 1'b1 || obs_ir !== word) begin
        tests_failed++;
        $display("[TB] FAIL random %0d fetch: got timeout=%b addr=%h stable=%b ir=%h expected 0 %h 1 %h",
                 i, obs_timeout, obs_start_addr, obs_wait_ok, obs_ir, m_pc, word);
      end
      tests_run++;
      if (obs_stat_we_v !== (alu ? EXP_STAT_WE : 16'h0) || obs_rf_we_v !== (alu ? EXP_RF_WE : 16'h0) ||
          obs_alu_v !== (alu ? EXP_ALU : 16'h0) || obs_misc_bad !== 1'b0 || obs_halted_v !== 16'h0) begin
        tests_failed++;
        $display("[TB] FAIL random %0d strobes op=%h: got stat_we=%h rf_we=%h alu=%h bad=%b halted=%h alu_class=%b",
                 i, word[31:28], obs_stat_we_v, obs_rf_we_v, obs_alu_v, obs_misc_bad, obs_halted_v, alu);
      end
      tests_run++;
      if (obs_next_addr !== exp_next || obs_req_v !== EXP_REQ) begin
        tests_failed++;
        $display("[TB] FAIL random %0d next pc op=%h stat=%b: got %h req=%h expected %h req=%h",
                 i, word[31:28], st, obs_next_addr, obs_req_v, exp_next, EXP_REQ);
      end
      tests_run++;
      if (obs_icount !== m_icount) begin
        tests_failed++;
        $display("[TB] FAIL random %0d icount: got %0d expected %0d", i, obs_icount, m_icount);
      end
      m_pc = exp_next;
    end
  endtask

  task automatic test_reset_abort;
    // Reset while a fetch request is outstanding.
    tests_run++;
    if (imem_req !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort setup: got req=%b expected 1", imem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (imem_req !== 1'b0 || pc !== 16'h0 || icount !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL abort mid-fetch: got req=%b pc=%h icount=%h expected 0 0000 0000", imem_req, pc, icount);
    end
    m_pc = 16'd0;
    m_icount = 16'd0;
    // Reset in DECODE of an ALU instruction: stat_we must never fire.
    run_instr({4'h1, 28'($urandom)}, 0, 4'($urandom), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (stat_we !== 1'b0 || rf_we !== 1'b0 || alu_op !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL abort in decode cycle %0d: got stat_we=%b rf_we=%b alu_op=%h expected 0 0 0",
                 c, stat_we, rf_we, alu_op);
      end
      @(negedge clk);
    end
    // Reset in MEM of an ALU instruction: rf_we must never fire, nothing retires.
    run_instr({4'h1, 28'($urandom)}, 0, 4'($urandom), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if (rf_we !== 1'b0 || icount !== 16'h0) begin
        tests_failed++;
        $display("[TB] FAIL abort in mem cycle %0d: got rf_we=%b icount=%0d expected 0 0", c, rf_we, icount);
      end
      @(negedge clk);
    end
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL abort restart: got req=%b addr=%h expected 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_halt;
    run_instr({4'h0, 28'($urandom)}, 0, 4'($urandom), 5);
    m_icount = m_icount + 16'd1;
    m_pc     = m_pc + 16'd1;
    run_instr({4'hF, 28'($urandom)}, 1, 4'($urandom), 12);
    tests_run++;
    if (obs_halted_v !== EXP_HALTED) begin
      tests_failed++;
      $display("[TB] FAIL halt timing: got halted=%h expected %h", obs_halted_v, EXP_HALTED);
    end
    tests_run++;
    if (obs_req_v !== 16'h0 || {obs_stat_we_v, obs_rf_we_v, obs_alu_v} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL halt quiet: got req=%h stat_we=%h rf_we=%h alu=%h expected all 0",
               obs_req_v, obs_stat_we_v, obs_rf_we_v, obs_alu_v);
    end
    tests_run++;
    if (obs_icount !== m_icount) begin
      tests_failed++;
      $display("[TB] FAIL halt icount: got %0d expected %0d", obs_icount, m_icount);
    end
    do_reset(1);
    run_instr({4'h0, 28'($urandom)}, 0, 4'($urandom), 5);
    tests_run++;
    if (obs_timeout !== 1'b0 || obs_start_addr !== 16'h0000 || obs_next_addr !== 16'h0001 ||
        obs_icount !== 16'd1 || obs_halted_v !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL resume after halt: got timeout=%b addr=%h next=%h icount=%0d halted=%h expected 0 0000 0001 1 0",
               obs_timeout, obs_start_addr, obs_next_addr, obs_icount, obs_halted_v);
    end
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stat       = 4'h0;
    m_pc       = 16'd0;
    m_icount   = 16'd0;
    test_reset();
    test_alu_timing(0);
    test_alu_timing(4);
    test_alu_timing(1);
    test_branches();
    test_pc_wrap();
    test_random();
    test_reset_abort();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
